// File: rtl/link_ddr_downstream_sipo.sv
// Receive-side DDR link stage: reassembles per-clock link beats into core words,
// buffers them in a small FIFO and returns credit tokens as words are consumed.
module link_ddr_downstream_sipo #(
    parameter int CH_W             = 8,
    parameter int NUM_CH           = 2,
    parameter int WORD_W           = 64,
    parameter int FIFO_DEPTH       = 4,
    parameter int TOKEN_DECIMATION = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        io_valid_i,
    input  logic [2*NUM_CH*CH_W-1:0] io_data_i,
    output logic                     core_valid_o,
    output logic [WORD_W-1:0]        core_data_o,
    input  logic                     core_ready_i,
    output logic [NUM_CH-1:0]        token_o,
    output logic                     err_overflow_o,
    output logic                     err_skew_o
);

    localparam int BEAT_W = 2 * NUM_CH * CH_W;
    localparam int BEATS  = WORD_W / BEAT_W;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int DW     = (TOKEN_DECIMATION > 1) ? $clog2(TOKEN_DECIMATION) : 1;

    logic [CNT_W-1:0]  beat_cnt_r;
    logic [WORD_W-1:0] asm_r;
    logic [WORD_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic [DW-1:0]     deq_cnt_r;
    logic [NUM_CH-1:0] token_r;
    logic              err_overflow_r;
    logic              err_skew_r;

    logic              all_valid_s;
    logic              skew_s;
    logic              last_beat_s;
    logic [WORD_W-1:0] word_s;
    logic              empty_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              overflow_s;
    logic              tok_wrap_s;

    // Beat classification, word assembly and FIFO push/pop decisions.
    always_comb begin
        all_valid_s = &io_valid_i;
        skew_s      = (|io_valid_i) && !all_valid_s;
        last_beat_s = all_valid_s && (beat_cnt_r == CNT_W'(BEATS - 1));
        word_s      = asm_r;
        word_s[(BEATS-1)*BEAT_W +: BEAT_W] = io_data_i;
        empty_s     = (wr_ptr_r == rd_ptr_r);
        full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s       = !empty_s && core_ready_i;
        // A full FIFO still accepts a word when the head leaves on the same edge.
        push_s      = last_beat_s && (!full_s || pop_s);
        overflow_s  = last_beat_s && full_s && !pop_s;
        tok_wrap_s  = pop_s && (deq_cnt_r == DW'(TOKEN_DECIMATION - 1));
    end

    // Beat counter and assembly register; skew throws away the partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_r <= '0;
        end else if (skew_s) begin
            beat_cnt_r <= '0;
        end else if (all_valid_s) begin
            asm_r[beat_cnt_r*BEAT_W +: BEAT_W] <= io_data_i;
            if (last_beat_s) begin
                beat_cnt_r <= '0;
            end else begin
                beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            end
        end
    end

    // FIFO storage and wrap-bit pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= word_s;
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Dequeue counter and credit token toggling.
    always_ff @(posedge clk) begin
        if (rst) begin
            deq_cnt_r <= '0;
            token_r   <= '0;
        end else if (pop_s) begin
            if (tok_wrap_s) begin
                deq_cnt_r <= '0;
                token_r   <= ~token_r;
            end else begin
                deq_cnt_r <= deq_cnt_r + DW'(1);
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_overflow_r <= 1'b0;
            err_skew_r     <= 1'b0;
        end else begin
            if (overflow_s) begin
                err_overflow_r <= 1'b1;
            end
            if (skew_s) begin
                err_skew_r <= 1'b1;
            end
        end
    end

    assign core_valid_o   = !empty_s;
    assign core_data_o    = mem_r[rd_ptr_r[AW-1:0]];
    assign token_o        = token_r;
    assign err_overflow_o = err_overflow_r;
    assign err_skew_o     = err_skew_r;

endmodule

// File: tb/tb_link_ddr_downstream_sipo.sv
// Directed bench for link_ddr_downstream_sipo with hand-computed expectations.
module tb_link_ddr_downstream_sipo;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  io_valid_i;
    logic [31:0] io_data_i;
    logic        core_valid_o;
    logic [63:0] core_data_o;
    logic        core_ready_i;
    logic [1:0]  token_o;
    logic        err_overflow_o;
    logic        err_skew_o;

    int checks   = 0;
    int failures = 0;

    link_ddr_downstream_sipo dut (
        .clk            (clk),
        .rst            (rst),
        .io_valid_i     (io_valid_i),
        .io_data_i      (io_data_i),
        .core_valid_o   (core_valid_o),
        .core_data_o    (core_data_o),
        .core_ready_i   (core_ready_i),
        .token_o        (token_o),
        .err_overflow_o (err_overflow_o),
        .err_skew_o     (err_skew_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d);
        io_valid_i = 2'b11;
        io_data_i  = d;
        tick();
        io_valid_i = 2'b00;
        io_data_i  = 32'h0;
    endtask

    task automatic send_word(input logic [63:0] w);
        beat(w[31:0]);
        beat(w[63:32]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [63:0] wv(input int i);
        logic [31:0] k;
        k = i;
        return {32'hB0B0_0000 + k, 32'hA0A0_0000 + k};
    endfunction

    function automatic logic [1:0] tok_after(input int pops);
        return ((pops / 2) % 2 == 1) ? 2'b11 : 2'b00;
    endfunction

    initial begin
        rst          = 1'b1;
        io_valid_i   = 2'b00;
        io_data_i    = 32'h0;
        core_ready_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("reset_valid", core_valid_o, 64'd0);
        check("reset_token", token_o, 64'd0);
        check("reset_ovf", err_overflow_o, 64'd0);
        check("reset_skew", err_skew_o, 64'd0);

        // Single word
        beat(32'h3322_1100);
        check("single_no_early_valid", core_valid_o, 64'd0);
        beat(32'h7766_5544);
        check("single_valid", core_valid_o, 64'd1);
        check("single_data", core_data_o, 64'h7766_5544_3322_1100);
        core_ready_i = 1'b1;
        tick();
        core_ready_i = 1'b0;
        check("single_empty_after_pop", core_valid_o, 64'd0);
        check("single_token_one_pop", token_o, 64'd0);

        // Fill, overflow, drain
        do_reset();
        for (int i = 0; i < 4; i++) send_word(wv(i));
        check("fill_valid", core_valid_o, 64'd1);
        check("fill_head", core_data_o, wv(0));
        check("fill_no_ovf", err_overflow_o, 64'd0);
        send_word(64'hDEAD_DEAD_DEAD_DEAD);
        check("ovf_flag", err_overflow_o, 64'd1);
        check("ovf_head_intact", core_data_o, wv(0));
        core_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_valid_%0d", i), core_valid_o, 64'd1);
            check($sformatf("drain_data_%0d", i), core_data_o, wv(i));
            tick();
            check($sformatf("drain_token_%0d", i), token_o, tok_after(i + 1));
        end
        core_ready_i = 1'b0;
        check("drain_empty", core_valid_o, 64'd0);
        check("ovf_sticky", err_overflow_o, 64'd1);

        // Full with simultaneous push and pop
        do_reset();
        check("reset_clears_ovf", err_overflow_o, 64'd0);
        for (int i = 0; i < 4; i++) send_word(wv(i));
        beat(wv(4)[31:0]);
        core_ready_i = 1'b1;
        beat(wv(4)[63:32]);
        check("pp_no_ovf", err_overflow_o, 64'd0);
        check("pp_token", token_o, tok_after(1));
        for (int i = 1; i < 5; i++) begin
            check($sformatf("pp_valid_%0d", i), core_valid_o, 64'd1);
            check($sformatf("pp_data_%0d", i), core_data_o, wv(i));
            tick();
            check($sformatf("pp_token_%0d", i), token_o, tok_after(i + 1));
        end
        core_ready_i = 1'b0;
        check("pp_empty", core_valid_o, 64'd0);
        check("pp_no_ovf_end", err_overflow_o, 64'd0);

        // Skew discards the partial word
        do_reset();
        beat(32'hAAAA_AAAA);
        io_valid_i = 2'b01;
        io_data_i  = 32'h5555_5555;
        tick();
        io_valid_i = 2'b00;
        io_data_i  = 32'h0;
        check("skew_flag", err_skew_o, 64'd1);
        check("skew_no_word", core_valid_o, 64'd0);
        beat(32'h0123_4567);
        tick();
        check("skew_idle_no_word", core_valid_o, 64'd0);
        beat(32'h89AB_CDEF);
        check("skew_recover_valid", core_valid_o, 64'd1);
        check("skew_recover_data", core_data_o, 64'h89AB_CDEF_0123_4567);
        check("skew_sticky", err_skew_o, 64'd1);
        core_ready_i = 1'b1;
        tick();
        core_ready_i = 1'b0;

        // Reset mid-word
        beat(32'hDEAD_BEEF);
        do_reset();
        check("midrst_empty", core_valid_o, 64'd0);
        check("midrst_skew_clear", err_skew_o, 64'd0);
        beat(32'h1111_2222);
        check("midrst_partial", core_valid_o, 64'd0);
        beat(32'h3333_4444);
        check("midrst_valid", core_valid_o, 64'd1);
        check("midrst_data", core_data_o, 64'h3333_4444_1111_2222);
        check("midrst_token", token_o, 64'd0);
        check("midrst_ovf", err_overflow_o, 64'd0);
        check("midrst_skew", err_skew_o, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
